// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word requests,
// and buffers returned instructions with their PCs for decode.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  cnt_t        count_q, count_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        discard_q, discard_d;

  logic [31:0] mem_data_q [DEPTH];
  logic [31:0] mem_pc_q   [DEPTH];

  logic [CNT_W:0] in_use;
  logic [31:0]    redirect_base;
  logic           accept;
  logic           rsp_ok;
  logic           drop;
  logic           push;
  logic           pop;
  logic           unused_redirect_lsbs;

  assign redirect_base        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = |redirect_pc[1:0];

  // Credits cover both buffered entries and in-flight requests, so a push can never overflow.
  assign in_use    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req  = reset && !redirect && (in_use < {1'b0, DEPTH_C});
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_ok = imem_rvalid && (outstanding_q != '0);
  assign drop   = rsp_ok && (discard_q != '0);
  assign push   = rsp_ok && !drop && !redirect;

  assign inst_valid = (count_q != '0) && !redirect;
  assign pop        = inst_valid && inst_ready;

  assign inst    = (count_q != '0) ? mem_data_q[head_q] : '0;
  assign inst_pc = (count_q != '0) ? mem_pc_q[head_q]   : '0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (redirect) begin
      // Everything still in flight belongs to the old path and must be squashed on return.
      fetch_pc_d    = redirect_base;
      resp_pc_d     = redirect_base;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      outstanding_d = outstanding_q - cnt_t'(rsp_ok);
      discard_d     = outstanding_q - cnt_t'(rsp_ok);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(rsp_ok);
      if (drop) begin
        discard_d = discard_q - cnt_t'(1);
      end
      if (push) begin
        tail_d    = tail_q + ptr_t'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q gates the outputs, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[tail_q] <= imem_rdata;
      mem_pc_q[tail_q]   <= resp_pc_q;
    end
  end

endmodule
